// File: rtl/peak_hold_multi.sv
// peak_hold_multi: per-period peak detector over NCH channels.
// Tracks each channel's running maximum and its sample index between period
// markers, publishes per-channel peaks on every marker, and feeds them through
// a pipelined comparator tree that reports the global peak and its channel.
module peak_hold_multi #(
    parameter int WIDTH  = 32,
    parameter int NCH    = 4,
    parameter int SIGNED = 0,
    parameter int IDX_W  = 16,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ms_in,
    input  logic                   din_valid,
    input  logic [NCH*WIDTH-1:0]   din,
    output logic [NCH*WIDTH-1:0]   max_out,
    output logic [NCH*IDX_W-1:0]   max_idx,
    output logic                   idx_sat,
    output logic [WIDTH-1:0]       max_all,
    output logic [CH_W-1:0]        max_all_ch,
    output logic                   out_valid
);

    localparam int LVL = $clog2(NCH);
    localparam logic [WIDTH-1:0] FLOOR = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    function automatic logic is_greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED != 0) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    logic             ms_s1_q, ms_s2_q;
    logic             edge_e;
    logic             commit_q, commit_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             idx_sat_q, idx_sat_d;
    logic [WIDTH-1:0] inner_q [NCH];
    logic [WIDTH-1:0] inner_d [NCH];
    logic [IDX_W-1:0] inner_idx_q [NCH];
    logic [IDX_W-1:0] inner_idx_d [NCH];
    logic [WIDTH-1:0] max_out_q [NCH];
    logic [WIDTH-1:0] max_out_d [NCH];
    logic [IDX_W-1:0] max_idx_q [NCH];
    logic [IDX_W-1:0] max_idx_d [NCH];

    logic [WIDTH-1:0] root_val;
    logic [CH_W-1:0]  root_ch;
    logic             root_valid;
    logic [WIDTH-1:0] max_all_q, max_all_d;
    logic [CH_W-1:0]  max_all_ch_q, max_all_ch_d;
    logic             out_valid_q, out_valid_d;

    // Two-flop synchroniser for the asynchronous period marker
    always_ff @(posedge clk) begin
        if (rst) begin
            ms_s1_q <= 1'b0;
            ms_s2_q <= 1'b0;
        end else begin
            ms_s1_q <= ms_in;
            ms_s2_q <= ms_s1_q;
        end
    end

    assign edge_e = ms_s1_q & ~ms_s2_q;

    // Period tracking: commit on a marker edge, otherwise fold in valid samples
    always_comb begin
        commit_d  = edge_e;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        idx_sat_d = idx_sat_q;
        inner_d     = inner_q;
        inner_idx_d = inner_idx_q;
        max_out_d   = max_out_q;
        max_idx_d   = max_idx_q;
        if (edge_e) begin
            idx_sat_d = sat_q;
            cnt_d     = '0;
            sat_d     = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                max_out_d[c]   = inner_q[c];
                max_idx_d[c]   = inner_idx_q[c];
                inner_d[c]     = FLOOR;
                inner_idx_d[c] = '0;
            end
        end else if (din_valid) begin
            for (int c = 0; c < NCH; c++) begin
                if (is_greater(din[c*WIDTH +: WIDTH], inner_q[c])) begin
                    inner_d[c]     = din[c*WIDTH +: WIDTH];
                    inner_idx_d[c] = cnt_q;
                end
            end
            if (cnt_q != IDX_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q >= IDX_MAX - 1'b1) begin
                sat_d = 1'b1;
            end
        end
    end

    // Period state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_q  <= 1'b0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            idx_sat_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                inner_q[c]     <= FLOOR;
                inner_idx_q[c] <= '0;
                max_out_q[c]   <= '0;
                max_idx_q[c]   <= '0;
            end
        end else begin
            commit_q    <= commit_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            idx_sat_q   <= idx_sat_d;
            inner_q     <= inner_d;
            inner_idx_q <= inner_idx_d;
            max_out_q   <= max_out_d;
            max_idx_q   <= max_idx_d;
        end
    end

    generate
        if (NCH == 1) begin : g_single
            assign root_val   = max_out_q[0];
            assign root_ch    = '0;
            assign root_valid = commit_q;
        end else begin : g_tree
            // Heap-ordered tree: node i has children 2i and 2i+1; leaves are the
            // published peaks, so every internal level adds one register stage.
            logic [WIDTH-1:0] tree_val_q [1:NCH-1];
            logic [WIDTH-1:0] tree_val_d [1:NCH-1];
            logic [CH_W-1:0]  tree_ch_q  [1:NCH-1];
            logic [CH_W-1:0]  tree_ch_d  [1:NCH-1];
            logic [WIDTH-1:0] node_val   [1:2*NCH-1];
            logic [CH_W-1:0]  node_ch    [1:2*NCH-1];
            logic [LVL-1:0]   vld_q, vld_d;

            // Gather registered internal nodes and leaf peaks into one node view
            always_comb begin
                for (int i = 1; i < NCH; i++) begin
                    node_val[i] = tree_val_q[i];
                    node_ch[i]  = tree_ch_q[i];
                end
                for (int i = NCH; i < 2*NCH; i++) begin
                    node_val[i] = max_out_q[i-NCH];
                    node_ch[i]  = CH_W'(i - NCH);
                end
            end

            // Each node keeps the larger child; the left (lower channel) wins ties
            always_comb begin
                for (int i = 1; i < NCH; i++) begin
                    if (is_greater(node_val[2*i+1], node_val[2*i])) begin
                        tree_val_d[i] = node_val[2*i+1];
                        tree_ch_d[i]  = node_ch[2*i+1];
                    end else begin
                        tree_val_d[i] = node_val[2*i];
                        tree_ch_d[i]  = node_ch[2*i];
                    end
                end
                vld_d[0] = commit_q;
                for (int k = 1; k < LVL; k++) begin
                    vld_d[k] = vld_q[k-1];
                end
            end

            // Tree node and valid-chain registers
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                    for (int i = 1; i < NCH; i++) begin
                        tree_val_q[i] <= '0;
                        tree_ch_q[i]  <= '0;
                    end
                end else begin
                    vld_q      <= vld_d;
                    tree_val_q <= tree_val_d;
                    tree_ch_q  <= tree_ch_d;
                end
            end

            assign root_val   = tree_val_q[1];
            assign root_ch    = tree_ch_q[1];
            assign root_valid = vld_q[LVL-1];
        end
    endgenerate

    // Final output stage captures the tree root when its pass completes
    always_comb begin
        max_all_d    = max_all_q;
        max_all_ch_d = max_all_ch_q;
        out_valid_d  = root_valid;
        if (root_valid) begin
            max_all_d    = root_val;
            max_all_ch_d = root_ch;
        end
    end

    // Global result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            max_all_q    <= '0;
            max_all_ch_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            max_all_q    <= max_all_d;
            max_all_ch_q <= max_all_ch_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Pack per-channel results onto the flat output buses
    always_comb begin
        max_out = '0;
        max_idx = '0;
        for (int c = 0; c < NCH; c++) begin
            max_out[c*WIDTH +: WIDTH] = max_out_q[c];
            max_idx[c*IDX_W +: IDX_W] = max_idx_q[c];
        end
    end

    assign idx_sat    = idx_sat_q;
    assign max_all    = max_all_q;
    assign max_all_ch = max_all_ch_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_peak_hold_multi.sv
// Testbench for peak_hold_multi: an unsigned and a signed instance (NCH=4,
// IDX_W=4) share one stimulus stream; a window-based model predicts every output
// each cycle, and hand-computed literals pin the model's results.
module tb_peak_hold_multi;

    localparam int W = 32;
    localparam int N = 4;
    localparam int IW = 4;
    localparam int LAT = 3;

    logic           clk;
    logic           rst;
    logic           ms_in;
    logic           din_valid;
    logic [N*W-1:0] din;

    logic [N*W-1:0]  mo_u, mo_s;
    logic [N*IW-1:0] mi_u, mi_s;
    logic            sat_u, sat_s;
    logic [W-1:0]    ma_u, ma_s;
    logic [1:0]      mach_u, mach_s;
    logic            ov_u, ov_s;

    int pass_cnt = 0;
    int total_cnt = 0;
    int pulses_u = 0;

    peak_hold_multi #(.WIDTH(W), .NCH(N), .SIGNED(0), .IDX_W(IW)) dut_u (
        .clk(clk), .rst(rst), .ms_in(ms_in), .din_valid(din_valid), .din(din),
        .max_out(mo_u), .max_idx(mi_u), .idx_sat(sat_u),
        .max_all(ma_u), .max_all_ch(mach_u), .out_valid(ov_u)
    );

    peak_hold_multi #(.WIDTH(W), .NCH(N), .SIGNED(1), .IDX_W(IW)) dut_s (
        .clk(clk), .rst(rst), .ms_in(ms_in), .din_valid(din_valid), .din(din),
        .max_out(mo_s), .max_idx(mi_s), .idx_sat(sat_s),
        .max_all(ma_s), .max_all_ch(mach_s), .out_valid(ov_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [31:0] all_v [2];
        logic [1:0]  all_c [2];
    } pend_t;

    logic [N*W-1:0]  win_q [$];
    pend_t           pend_q [$];
    logic [N*W-1:0]  exp_mo [2];
    logic [N*IW-1:0] exp_mi [2];
    logic            exp_sat [2];
    logic [W-1:0]    exp_ma [2];
    logic [1:0]      exp_ch [2];
    logic            exp_ov [2];
    logic            ms_h1, ms_h2;
    int              cyc = 0;

    function automatic bit gtM(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        if (sgn) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    // Scan the whole recorded window for one channel's first strict maximum
    function automatic void windowPeak(input bit sgn, input int c,
                                       output logic [31:0] peak, output int idx);
        logic [31:0] v;
        peak = sgn ? 32'h8000_0000 : 32'h0;
        idx = 0;
        for (int k = 0; k < win_q.size(); k++) begin
            v = win_q[k][c*W +: W];
            if (gtM(v, peak, sgn)) begin
                peak = v;
                idx = (k > 15) ? 15 : k;
            end
        end
    endfunction

    always @(posedge clk) begin
        logic        commit;
        logic [31:0] pk [N];
        int          ix;
        int          best;
        pend_t       p;
        if (rst) begin
            win_q.delete();
            pend_q.delete();
            ms_h1 = 1'b0;
            ms_h2 = 1'b0;
            for (int s = 0; s < 2; s++) begin
                exp_mo[s] = '0; exp_mi[s] = '0; exp_sat[s] = 1'b0;
                exp_ma[s] = '0; exp_ch[s] = '0; exp_ov[s] = 1'b0;
            end
        end else begin
            commit = ms_h1 && !ms_h2;
            ms_h2 = ms_h1;
            ms_h1 = ms_in;
            exp_ov[0] = 1'b0;
            exp_ov[1] = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                for (int s = 0; s < 2; s++) begin
                    exp_ma[s] = pend_q[0].all_v[s];
                    exp_ch[s] = pend_q[0].all_c[s];
                    exp_ov[s] = 1'b1;
                end
                void'(pend_q.pop_front());
            end
            if (commit) begin
                p.due = cyc + LAT;
                for (int s = 0; s < 2; s++) begin
                    for (int c = 0; c < N; c++) begin
                        windowPeak(s[0], c, pk[c], ix);
                        exp_mo[s][c*W +: W] = pk[c];
                        exp_mi[s][c*IW +: IW] = ix[IW-1:0];
                    end
                    exp_sat[s] = (win_q.size() >= 15);
                    best = 0;
                    for (int c = 1; c < N; c++) begin
                        if (gtM(pk[c], pk[best], s[0])) best = c;
                    end
                    p.all_v[s] = pk[best];
                    p.all_c[s] = best[1:0];
                end
                pend_q.push_back(p);
                win_q.delete();
            end else if (din_valid) begin
                win_q.push_back(din);
            end
        end
        cyc++;
    end

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (ov_u === 1'b1) pulses_u++;
            checkOutput("u_max_out", mo_u, exp_mo[0]);
            checkOutput("u_max_idx", 128'(mi_u), 128'(exp_mi[0]));
            checkOutput("u_idx_sat", 128'(sat_u), 128'(exp_sat[0]));
            checkOutput("u_max_all", 128'(ma_u), 128'(exp_ma[0]));
            checkOutput("u_max_all_ch", 128'(mach_u), 128'(exp_ch[0]));
            checkOutput("u_out_valid", 128'(ov_u), 128'(exp_ov[0]));
            checkOutput("s_max_out", mo_s, exp_mo[1]);
            checkOutput("s_max_idx", 128'(mi_s), 128'(exp_mi[1]));
            checkOutput("s_idx_sat", 128'(sat_s), 128'(exp_sat[1]));
            checkOutput("s_max_all", 128'(ma_s), 128'(exp_ma[1]));
            checkOutput("s_max_all_ch", 128'(mach_s), 128'(exp_ch[1]));
            checkOutput("s_out_valid", 128'(ov_s), 128'(exp_ov[1]));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [N*W-1:0] mk(input logic [31:0] c0, input logic [31:0] c1,
                                          input logic [31:0] c2, input logic [31:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic applyStimulus(input logic v, input logic [N*W-1:0] d, input logic m);
        @(negedge clk);
        din_valid = v;
        din = d;
        ms_in = m;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0);
    endtask

    task automatic pulseMs();
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
    endtask

    int base;
    logic [31:0] v0;

    initial begin
        rst = 1'b1;
        ms_in = 1'b0;
        din_valid = 1'b0;
        din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: single-channel peak
        base = pulses_u;
        applyStimulus(1'b1, mk(5, 0, 0, 0), 1'b0);
        applyStimulus(1'b1, mk(9, 0, 0, 0), 1'b0);
        applyStimulus(1'b1, mk(3, 0, 0, 0), 1'b0);
        pulseMs();
        idle(6);
        checkOutput("t1_ch0_max", 128'(mo_u[31:0]), 128'd9);
        checkOutput("t1_ch0_idx", 128'(mi_u[3:0]), 128'd1);
        checkOutput("t1_max_all", 128'(ma_u), 128'd9);
        checkOutput("t1_max_all_ch", 128'(mach_u), 128'd0);
        checkOutput("t1_pulses", 128'(pulses_u - base), 128'd1);

        // 2: cross-channel and within-channel ties
        applyStimulus(1'b1, mk(32'h10, 1, 32'h20, 0), 1'b0);
        applyStimulus(1'b1, mk(32'h10, 2, 32'h20, 0), 1'b0);
        applyStimulus(1'b1, mk(32'h10, 3, 32'h20, 0), 1'b0);
        applyStimulus(1'b1, mk(32'h10, 4, 32'h20, 0), 1'b0);
        applyStimulus(1'b1, mk(32'h10, 32'hFFFF_FFFF, 32'h20, 0), 1'b0);
        applyStimulus(1'b1, mk(32'h10, 5, 32'h20, 32'hFFFF_FFFF), 1'b0);
        applyStimulus(1'b1, mk(32'h10, 6, 32'h20, 0), 1'b0);
        applyStimulus(1'b1, mk(32'h10, 32'hFFFF_FFFF, 32'h20, 0), 1'b0);
        pulseMs();
        idle(6);
        checkOutput("t2_max_all_ch", 128'(mach_u), 128'd1);
        checkOutput("t2_max_all", 128'(ma_u), 128'hFFFF_FFFF);
        checkOutput("t2_ch1_idx", 128'(mi_u[7:4]), 128'd4);
        checkOutput("t2_ch3_idx", 128'(mi_u[15:12]), 128'd5);

        // 3: all-negative samples on ch2, other channels sit at the floor
        applyStimulus(1'b1, mk(32'h8000_0000, 32'h8000_0000, -32'sd7, 32'h8000_0000), 1'b0);
        applyStimulus(1'b1, mk(32'h8000_0000, 32'h8000_0000, -32'sd2, 32'h8000_0000), 1'b0);
        applyStimulus(1'b1, mk(32'h8000_0000, 32'h8000_0000, -32'sd9, 32'h8000_0000), 1'b0);
        pulseMs();
        idle(6);
        checkOutput("t3_s_ch2_max", 128'(mo_s[95:64]), 128'hFFFF_FFFE);
        checkOutput("t3_s_ch0_max", 128'(mo_s[31:0]), 128'h8000_0000);
        checkOutput("t3_s_max_all", 128'(ma_s), 128'hFFFF_FFFE);
        checkOutput("t3_s_max_all_ch", 128'(mach_s), 128'd2);

        // 4: index saturation, then a short period clears the flag
        for (int k = 0; k < 20; k++) begin
            v0 = (k == 18) ? 32'd1000 : 32'(k + 1);
            applyStimulus(1'b1, mk(v0, 0, 0, 0), 1'b0);
        end
        pulseMs();
        idle(2);
        checkOutput("t4_sat", 128'(sat_u), 128'd1);
        checkOutput("t4_idx", 128'(mi_u[3:0]), 128'd15);
        checkOutput("t4_max", 128'(mo_u[31:0]), 128'd1000);
        for (int k = 0; k < 10; k++) applyStimulus(1'b1, mk(32'(k + 1), 0, 0, 0), 1'b0);
        pulseMs();
        idle(6);
        checkOutput("t4b_sat", 128'(sat_u), 128'd0);
        checkOutput("t4b_idx", 128'(mi_u[3:0]), 128'd9);

        // 5: reset while a reduction is in flight, then a clean period
        applyStimulus(1'b1, mk(0, 0, 0, 32'd77), 1'b0);
        applyStimulus(1'b1, mk(0, 0, 0, 32'd88), 1'b0);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        base = pulses_u;
        @(negedge clk);
        rst = 1'b1;
        ms_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(6);
        checkOutput("t5_no_pulse", 128'(pulses_u - base), 128'd0);
        checkOutput("t5_max_out_zero", mo_u, 128'd0);
        checkOutput("t5_max_all_zero", 128'(ma_u), 128'd0);
        applyStimulus(1'b1, mk(0, 0, 0, 32'd7), 1'b0);
        applyStimulus(1'b1, mk(0, 0, 0, 32'd3), 1'b0);
        pulseMs();
        idle(6);
        checkOutput("t5_ch3_max", 128'(mo_u[127:96]), 128'd7);
        checkOutput("t5_max_all_ch", 128'(mach_u), 128'd3);

        // 6: marker toggling every cycle pair with samples always valid
        base = pulses_u;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, mk(32'((k*37 + 1) % 50), 32'((k*37 + 11) % 50),
                                   32'((k*37 + 22) % 50), 32'((k*37 + 33) % 50)), k[0] == 1'b0);
        end
        idle(8);
        checkOutput("t6_pulses", 128'(pulses_u - base), 128'd6);

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
